// File: rtl/yin_pitch_picker_module_pkg.sv
// Shared YIN constants and the pitch-picker FSM encoding.
package yin_pitch_picker_module_pkg;

  localparam int unsigned YIN_INTERMEDIATE_DATA_WIDTH = 64;
  localparam int unsigned YIN_MAX_TAU                 = 40;
  localparam int unsigned YIN_MIN_TAU                 = 2;
  localparam int unsigned YIN_SAMPLE_RATE             = 8000;
  localparam int unsigned YIN_FREQ_WIDTH              = 16;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDescend,
    StDivide,
    StDone
  } yin_pick_state_e;

endpackage

// File: rtl/yin_period_divider.sv
// Restoring divider: one quotient bit per cycle, Width cycles, remainder dropped.
module yin_period_divider #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [Width-1:0] dividend,
  input  logic [Width-1:0] divisor,
  output logic [Width-1:0] quotient,
  output logic             ready
);

  localparam int unsigned CntW = $clog2(Width + 1);

  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] rem_q, rem_d;
  logic [Width-1:0] quo_q, quo_d;
  logic [Width-1:0] div_q, div_d;

  logic [Width:0]   rem_shift;
  logic [Width:0]   trial;
  logic             fits;

  // Next-state: load on go, otherwise shift in one quotient bit per cycle.
  always_comb begin
    busy_d    = busy_q;
    ready_d   = 1'b0;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    rem_shift = {rem_q, quo_q[Width-1]};
    trial     = rem_shift - {1'b0, div_q};
    fits      = (rem_shift >= {1'b0, div_q});
    if (busy_q) begin
      rem_d = fits ? trial[Width-1:0] : rem_shift[Width-1:0];
      quo_d = {quo_q[Width-2:0], fits};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CntW'(1)) begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    end else if (go) begin
      busy_d = 1'b1;
      cnt_d  = CntW'(Width);
      rem_d  = '0;
      quo_d  = dividend;
      div_d  = divisor;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
    end
  end

  assign quotient = quo_q;
  assign ready    = ready_q;

endmodule

// File: rtl/yin_pitch_picker_module.sv
// YIN pitch picker: first threshold crossing plus local descent, else global minimum.
module yin_pitch_picker_module
  import yin_pitch_picker_module_pkg::*;
#(
  parameter int unsigned INTERMEDIATE_DATA_WIDTH = YIN_INTERMEDIATE_DATA_WIDTH,
  parameter int unsigned MAX_TAU                 = YIN_MAX_TAU,
  parameter int unsigned MIN_TAU                 = YIN_MIN_TAU,
  parameter int unsigned SAMPLE_RATE             = YIN_SAMPLE_RATE,
  parameter int unsigned FREQ_WIDTH              = YIN_FREQ_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic [MAX_TAU*INTERMEDIATE_DATA_WIDTH-1:0] results,
  input  logic [INTERMEDIATE_DATA_WIDTH-1:0]         threshold,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       found,
  output logic [$clog2(MAX_TAU)-1:0]                 tau_out,
  output logic [FREQ_WIDTH-1:0]                      freq_out
);

  localparam int unsigned Idw  = INTERMEDIATE_DATA_WIDTH;
  localparam int unsigned TauW = $clog2(MAX_TAU);
  localparam logic [TauW-1:0] FirstTau = TauW'(MIN_TAU);
  localparam logic [TauW-1:0] LastTau  = TauW'(MAX_TAU - 1);

  yin_pick_state_e state_q, state_d;

  logic [MAX_TAU*Idw-1:0] snap_q, snap_d;
  logic [Idw-1:0]         thr_q, thr_d;
  logic [TauW-1:0]        tau_q, tau_d;
  logic [TauW-1:0]        cand_q, cand_d;
  logic [Idw-1:0]         min_val_q, min_val_d;
  logic [TauW-1:0]        min_tau_q, min_tau_d;
  logic [TauW-1:0]        sel_tau_q, sel_tau_d;
  logic                   sel_found_q, sel_found_d;
  logic                   go_q, go_d;
  logic                   found_q, found_d;
  logic [TauW-1:0]        tau_out_q, tau_out_d;
  logic [FREQ_WIDTH-1:0]  freq_out_q, freq_out_d;

  logic [Idw-1:0]         scan_val, cand_val, next_val;
  logic [TauW-1:0]        next_idx;
  logic                   cand_at_end;
  logic [FREQ_WIDTH-1:0]  div_quotient;
  logic                   div_ready;

  // Slot reads from the snapshot; next_idx saturates so the read stays in range.
  always_comb begin
    cand_at_end = (cand_q == LastTau);
    next_idx    = cand_at_end ? cand_q : cand_q + 1'b1;
    scan_val    = snap_q[32'(tau_q)*Idw +: Idw];
    cand_val    = snap_q[32'(cand_q)*Idw +: Idw];
    next_val    = snap_q[32'(next_idx)*Idw +: Idw];
  end

  // FSM next-state, scan/descend bookkeeping and result capture.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    thr_d       = thr_q;
    tau_d       = tau_q;
    cand_d      = cand_q;
    min_val_d   = min_val_q;
    min_tau_d   = min_tau_q;
    sel_tau_d   = sel_tau_q;
    sel_found_d = sel_found_q;
    go_d        = 1'b0;
    found_d     = found_q;
    tau_out_d   = tau_out_q;
    freq_out_d  = freq_out_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d    = results;
          thr_d     = threshold;
          tau_d     = FirstTau;
          min_val_d = '1;
          // Never zero, so the divider always sees a non-zero divisor.
          min_tau_d = FirstTau;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (scan_val < thr_q) begin
          cand_d  = tau_q;
          state_d = StDescend;
        end else begin
          if (scan_val < min_val_q) begin
            min_val_d = scan_val;
            min_tau_d = tau_q;
          end
          if (tau_q == LastTau) begin
            sel_tau_d   = min_tau_d;
            sel_found_d = 1'b0;
            go_d        = 1'b1;
            state_d     = StDivide;
          end else begin
            tau_d = tau_q + 1'b1;
          end
        end
      end
      StDescend: begin
        if (!cand_at_end && (next_val < cand_val)) begin
          cand_d = next_idx;
        end else begin
          sel_tau_d   = cand_q;
          sel_found_d = 1'b1;
          go_d        = 1'b1;
          state_d     = StDivide;
        end
      end
      StDivide: begin
        if (div_ready) begin
          found_d    = sel_found_q;
          tau_out_d  = sel_tau_q;
          freq_out_d = div_quotient;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset clears everything except min_val, which rests at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      thr_q       <= '0;
      tau_q       <= '0;
      cand_q      <= '0;
      min_val_q   <= '1;
      min_tau_q   <= '0;
      sel_tau_q   <= '0;
      sel_found_q <= 1'b0;
      go_q        <= 1'b0;
      found_q     <= 1'b0;
      tau_out_q   <= '0;
      freq_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      thr_q       <= thr_d;
      tau_q       <= tau_d;
      cand_q      <= cand_d;
      min_val_q   <= min_val_d;
      min_tau_q   <= min_tau_d;
      sel_tau_q   <= sel_tau_d;
      sel_found_q <= sel_found_d;
      go_q        <= go_d;
      found_q     <= found_d;
      tau_out_q   <= tau_out_d;
      freq_out_q  <= freq_out_d;
    end
  end

  yin_period_divider #(
    .Width (FREQ_WIDTH)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .go       (go_q),
    .dividend (FREQ_WIDTH'(SAMPLE_RATE)),
    .divisor  (FREQ_WIDTH'(sel_tau_q)),
    .quotient (div_quotient),
    .ready    (div_ready)
  );

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign found    = found_q;
  assign tau_out  = tau_out_q;
  assign freq_out = freq_out_q;

endmodule

// File: tb/tb_yin_pitch_picker_module.sv
// Scoreboard bench for the YIN pitch picker: directed cases plus randomized slots.
module tb_yin_pitch_picker_module;

  localparam int unsigned IDW = 64;
  localparam int unsigned MT  = 40;
  localparam int unsigned MN  = 2;
  localparam int unsigned SR  = 8000;
  localparam int unsigned FW  = 16;
  localparam int unsigned TW  = $clog2(MT);

  typedef logic [IDW-1:0] slots_t [MT];
  typedef struct {
    bit found;
    int tau;
    int freq;
    int cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [MT*IDW-1:0] results;
  logic [IDW-1:0]    threshold;
  logic              busy, done, found;
  logic [TW-1:0]     tau_out;
  logic [FW-1:0]     freq_out;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yin_pitch_picker_module #(
    .INTERMEDIATE_DATA_WIDTH (IDW),
    .MAX_TAU                 (MT),
    .MIN_TAU                 (MN),
    .SAMPLE_RATE             (SR),
    .FREQ_WIDTH              (FW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .results   (results),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .tau_out   (tau_out),
    .freq_out  (freq_out)
  );

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: first crossing then walk downhill; else lowest-tau global minimum.
  function automatic void model(input slots_t s, input logic [IDW-1:0] thr, output bit f,
                                output int tau, output int freq, output int lat);
    int k;
    int c;
    k = -1;
    for (int t = MN; t < MT; t++) if (k < 0 && s[t] < thr) k = t;
    if (k >= 0) begin
      c = k;
      while (c + 1 < MT && s[c+1] < s[c]) c++;
      f   = 1'b1;
      tau = c;
      lat = (k - MN + 1) + (c - k + 1) + FW + 2;
    end else begin
      c = MN;
      for (int t = MN; t < MT; t++) if (s[t] < s[c]) c = t;
      f   = 1'b0;
      tau = c;
      lat = (MT - MN) + FW + 2;
    end
    freq = SR / tau;
  endfunction

  function automatic slots_t fill(input logic [IDW-1:0] v);
    slots_t r;
    for (int t = 0; t < MT; t++) r[t] = v;
    return r;
  endfunction

  function automatic logic [MT*IDW-1:0] pack(input slots_t s);
    logic [MT*IDW-1:0] r;
    for (int t = 0; t < MT; t++) r[t*IDW +: IDW] = s[t];
    return r;
  endfunction

  // Called just after a falling edge; pulses start for one cycle.
  task automatic issue(input slots_t s, input logic [IDW-1:0] thr, input bit push,
                       input bit ef, input int et, input int efq);
    bit   mf;
    int   mt, mq, lat;
    exp_t e;
    model(s, thr, mf, mt, mq, lat);
    if (push) begin
      e.found = ef;
      e.tau   = et;
      e.freq  = efq;
      e.cyc   = cyc + 1 + lat;
      sb.push_back(e);
    end
    results   = pack(s);
    threshold = thr;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_completes"}, (n < 400) ? 1 : 0, 1);
    sb.delete();
  endtask

  // mode 1: second start during SCAN; mode 2: start during the done cycle.
  task automatic run_case(input string nm, input slots_t s, input logic [IDW-1:0] thr,
                          input bit ef, input int et, input int efq, input int mode,
                          input slots_t alt);
    int n;
    issue(s, thr, 1'b1, ef, et, efq);
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      results = pack(alt);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
    end else if (mode == 2) begin
      n = 0;
      while (done !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk({nm, "_done_seen"}, (n < 200) ? 1 : 0, 1);
      results = pack(alt);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      chk({nm, "_start_in_done_ignored_busy"}, busy, 0);
    end
    wait_idle(nm);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("found", found, e.found);
          chk("tau_out", tau_out, e.tau);
          chk("freq_out", freq_out, e.freq);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    slots_t a, b, c, d;
    bit     mf;
    int     mt, mq, ml;

    reset     = 1'b1;
    start     = 1'b1;
    results   = '0;
    threshold = '0;
    fork
      monitor();
    join_none

    // Reset beats a simultaneous start.
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_found", found, 0);
    chk("reset_tau", tau_out, 0);
    chk("reset_freq", freq_out, 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    a = fill(1000); a[10] = 90; a[11] = 60; a[12] = 80;
    b = fill(1000); b[20] = 300; b[25] = 300;
    c = fill(1000);
    for (int t = 30; t < 40; t++) c[t] = IDW'(99 - (t - 30));
    d = fill(1000); d[5] = 100; d[6] = 40;

    run_case("crossing_descent", a, 100, 1'b1, 11, 727, 0, a);
    run_case("fallback_min", b, 100, 1'b0, 20, 400, 0, b);
    run_case("descend_to_edge", c, 100, 1'b1, 39, 205, 0, c);
    run_case("threshold_equal", d, 100, 1'b1, 6, 1333, 2, a);
    run_case("start_while_busy", b, 100, 1'b0, 20, 400, 1, a);

    // Reset while the divider is running: no done, outputs cleared.
    model(a, 100, mf, mt, mq, ml);
    issue(a, 100, 1'b0, 1'b0, 0, 0);
    repeat (ml - 5) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    chk("midreset_found", found, 0);
    chk("midreset_tau", tau_out, 0);
    chk("midreset_freq", freq_out, 0);
    repeat (ml + 5) @(negedge clk);
    run_case("after_reset", a, 100, 1'b1, 11, 727, 0, a);

    for (int it = 0; it < 30; it++) begin
      slots_t         r;
      logic [IDW-1:0] thr;
      bit             fb;
      int             sel;
      thr = IDW'($urandom_range(50, 200));
      fb  = ($urandom_range(0, 2) == 0);
      for (int t = 0; t < MT; t++) begin
        sel = $urandom_range(0, 7);
        if (t > 0 && sel == 0) r[t] = r[t-1];
        else if (sel == 1) r[t] = {$urandom, $urandom};
        else if (fb) r[t] = thr + IDW'($urandom_range(0, 1000));
        else r[t] = IDW'($urandom_range(0, 1500));
      end
      model(r, thr, mf, mt, mq, ml);
      run_case("random", r, thr, mf, mt, mq, 0, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
